// File: rtl/drp_master_pkg.sv
// rtl/drp_master_pkg.sv - shared types and constants for the DRP initiator
package drp_master_pkg;

  localparam int DW = 32;

  typedef enum logic [1:0] {READ = 2'd0, WRITE = 2'd1, RMW = 2'd2, RSVD = 2'd3} drp_op_t;
  typedef enum logic [1:0] {OK = 2'd0, TIMEOUT = 2'd1, BADADDR = 2'd2, BADOP = 2'd3} drp_err_t;
  typedef enum logic [2:0] {IDLE, RD_EN, RD_WAIT, WR_EN, WR_WAIT, RESP} drp_st_t;

endpackage

// File: rtl/drp_master_if.sv
// rtl/drp_master_if.sv - command, response and DRP port bundle of the DRP initiator
interface drp_master_if
  import drp_master_pkg::*;
#(
  parameter int AW_FPGA = 11
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [AW_FPGA-1:0] cmd_addr;
  logic [DW-1:0]      cmd_wdata;
  logic [DW-1:0]      cmd_mask;
  logic               cmd_int_reg;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DW-1:0]      rsp_rdata;
  logic [1:0]         rsp_err;
  logic [AW_FPGA-1:0] drpaddr;
  logic [DW-1:0]      drpdi;
  logic               drpen;
  logic               drpwe;
  logic               int_reg;
  logic [DW-1:0]      drpdo;
  logic               drprdy;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, cmd_int_reg, rsp_ready, drpdo, drprdy,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, drpaddr, drpdi, drpen, drpwe, int_reg
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, cmd_int_reg, rsp_ready, drpdo, drprdy,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, drpaddr, drpdi, drpen, drpwe, int_reg
  );

endinterface

// File: rtl/drp_master_wdog.sv
// rtl/drp_master_wdog.sv - wait counter that flags expiry on the LIMIT-th enabled cycle
module drp_wdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  // Combinational so the FSM can leave on the very cycle the budget runs out.
  assign expired = (cnt >= LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/drp_master.sv
// rtl/drp_master.sv - single-outstanding DRP initiator with RMW, timeout and range check
module drp_master
  import drp_master_pkg::*;
#(
  parameter int N           = 2,
  parameter int AW_QUAD     = 9,
  parameter int AW_FPGA     = 11,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         drp_clk,
  input  logic         drp_rst_n,
  drp_master_if.master bus
);

  drp_st_t                    state, state_d;
  drp_op_t                    op_q, cmd_op;
  drp_err_t                   rsp_err_q, rsp_err_d;
  logic [DW-1:0]              wdata_q, mask_q, rd_q;
  logic [DW-1:0]              rsp_rdata_q, rsp_rdata_d, drpdi_q, drpdi_d;
  logic [AW_FPGA-1:0]         drpaddr_q, drpaddr_d;
  logic [AW_FPGA-AW_QUAD-1:0] quad;
  logic                       int_q, cmd_ready_q, rsp_valid_q, drpen_q, drpwe_q, int_reg_q;
  logic                       accept, in_en, in_wait, expired, en_d, int_d;

  assign cmd_op  = drp_op_t'(bus.cmd_op);
  assign quad    = bus.cmd_addr[AW_FPGA-1:AW_QUAD];
  assign accept  = bus.cmd_valid && cmd_ready_q;
  assign in_en   = (state == RD_EN) || (state == WR_EN);
  assign in_wait = (state == RD_WAIT) || (state == WR_WAIT);

  drp_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
    .clk(drp_clk), .rst_n(drp_rst_n), .clr(in_en), .en(in_wait), .expired(expired)
  );

  always_comb begin
    state_d     = state;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    drpaddr_d   = drpaddr_q;
    drpdi_d     = drpdi_q;
    case (state)
      IDLE: if (accept) begin
        if (cmd_op == RSVD) begin
          state_d = RESP; rsp_err_d = BADOP; rsp_rdata_d = '0;
        end else if (int'(quad) >= N) begin
          state_d = RESP; rsp_err_d = BADADDR; rsp_rdata_d = '0;
        end else begin
          drpaddr_d = bus.cmd_addr;
          drpdi_d   = bus.cmd_wdata;
          state_d   = (cmd_op == WRITE) ? WR_EN : RD_EN;
        end
      end
      RD_EN: state_d = RD_WAIT;
      WR_EN: state_d = WR_WAIT;
      // rdy is tested before expiry so a response on the last budget cycle still wins.
      RD_WAIT: if (bus.drprdy) begin
        if (op_q == RMW) begin
          drpdi_d = (bus.drpdo & ~mask_q) | (wdata_q & mask_q);
          state_d = WR_EN;
        end else begin
          state_d = RESP; rsp_err_d = OK; rsp_rdata_d = bus.drpdo;
        end
      end else if (expired) begin
        state_d = RESP; rsp_err_d = TIMEOUT; rsp_rdata_d = '0;
      end
      WR_WAIT: if (bus.drprdy) begin
        state_d = RESP; rsp_err_d = OK; rsp_rdata_d = (op_q == RMW) ? rd_q : '0;
      end else if (expired) begin
        state_d = RESP; rsp_err_d = TIMEOUT; rsp_rdata_d = '0;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign en_d  = (state_d == RD_EN) || (state_d == WR_EN);
  assign int_d = en_d && ((state == IDLE) ? bus.cmd_int_reg : int_q);

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge drp_clk or negedge drp_rst_n) begin
    if (!drp_rst_n) begin
      state       <= IDLE;
      op_q        <= READ;
      wdata_q     <= '0;
      mask_q      <= '0;
      rd_q        <= '0;
      int_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= OK;
      drpaddr_q   <= '0;
      drpdi_q     <= '0;
      drpen_q     <= 1'b0;
      drpwe_q     <= 1'b0;
      int_reg_q   <= 1'b0;
    end else begin
      state       <= state_d;
      cmd_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == RESP);
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      drpaddr_q   <= drpaddr_d;
      drpdi_q     <= drpdi_d;
      drpen_q     <= en_d;
      drpwe_q     <= (state_d == WR_EN);
      int_reg_q   <= int_d;
      if (accept) begin
        op_q    <= cmd_op;
        wdata_q <= bus.cmd_wdata;
        mask_q  <= bus.cmd_mask;
        int_q   <= bus.cmd_int_reg;
      end
      if (state == RD_WAIT && bus.drprdy) rd_q <= bus.drpdo;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.drpaddr   = drpaddr_q;
  assign bus.drpdi     = drpdi_q;
  assign bus.drpen     = drpen_q;
  assign bus.drpwe     = drpwe_q;
  assign bus.int_reg   = int_reg_q;

endmodule

// File: tb/tb_drp_master.sv
// tb/tb_drp_master.sv - randomized bench for drp_master against a transaction-level model
module tb_drp_master;
  import drp_master_pkg::*;

  localparam int T = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  drp_master_if #(.AW_FPGA(11)) bus ();

  drp_master #(.N(2), .AW_QUAD(9), .AW_FPGA(11), .TIMEOUT_CYC(T)) dut (
    .drp_clk(clk), .drp_rst_n(rst_n), .bus(bus)
  );

  int vectors = 0;
  int errors  = 0;

  int          lat_rd = 1, lat_wr = 1;
  logic [10:0] exp_addr = '0;
  logic [31:0] exp_wdi = '0;
  logic        exp_ir = 1'b0;
  bit          chk_on = 1'b1;

  int          n_en = 0, n_we = 0, n_ir = 0;
  bit          pending = 1'b0;
  bit          pend_we = 1'b0;
  int          cnt = 0;
  int          pa = 0;
  logic [31:0] pd = '0;
  logic [31:0] slv_mem [int];
  logic [31:0] ref_mem [int];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] seed(input int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int dur(input int l);
    return (l >= 1 && l <= T) ? l + 1 : T + 1;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Behavioural DRP slave: answers each drpen after a programmed delay (0 = never).
  always @(negedge clk) begin
    bus.drprdy = 1'b0;
    bus.drpdo  = $urandom();
    if (bus.drpen)   n_en++;
    if (bus.drpwe)   n_we++;
    if (bus.int_reg) n_ir++;
    if (pending) begin
      if (chk_on) begin
        check("addr_hold", bus.drpaddr, exp_addr);
        if (pend_we) check("wdata_hold", bus.drpdi, exp_wdi);
      end
      cnt--;
      if (cnt == 0) begin
        pending = 1'b0;
        bus.drprdy = 1'b1;
        if (pend_we) slv_mem[pa] = pd;
        else bus.drpdo = slv_mem.exists(pa) ? slv_mem[pa] : seed(pa);
      end
    end
    if (bus.drpen) begin
      if (chk_on) begin
        check("en_addr", bus.drpaddr, exp_addr);
        check("en_int_reg", bus.int_reg, exp_ir);
        if (bus.drpwe) check("en_wdata", bus.drpdi, exp_wdi);
      end
      pend_we = bus.drpwe;
      pa      = int'(bus.drpaddr);
      pd      = bus.drpdi;
      cnt     = bus.drpwe ? lat_wr : lat_rd;
      pending = (cnt > 0);
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 20 && !bus.cmd_ready; i++) step();
    check("cmd_ready_idle", bus.cmd_ready, 1'b1);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [10:0] a, input logic [31:0] wd,
                         input logic [31:0] m, input logic ir, input int lr, input int lw,
                         input int hold);
    logic [31:0] old, er;
    logic [1:0]  ee;
    int          k, ep, ew, t, en0, we0, ir0;
    bit          rok, wok;
    old = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : seed(int'(a));
    rok = (lr >= 1 && lr <= T);
    wok = (lw >= 1 && lw <= T);
    ep = 0; ew = 0; er = '0; k = 1;
    if (op == 2'd3) begin
      ee = 2'd3;
    end else if (a[10:9] >= 2'd2) begin
      ee = 2'd2;
    end else if (op == 2'd0) begin
      ee = rok ? 2'd0 : 2'd1; er = rok ? old : '0; k = 1 + dur(lr); ep = 1;
    end else if (op == 2'd1) begin
      ee = wok ? 2'd0 : 2'd1; k = 1 + dur(lw); ep = 1; ew = 1;
      exp_wdi = wd;
      if (lw != 0) ref_mem[int'(a)] = wd;
    end else if (!rok) begin
      ee = 2'd1; k = 1 + dur(lr); ep = 1;
    end else begin
      ee = wok ? 2'd0 : 2'd1; er = wok ? old : '0; k = 1 + dur(lr) + dur(lw); ep = 2; ew = 1;
      exp_wdi = (old & ~m) | (wd & m);
      if (lw != 0) ref_mem[int'(a)] = exp_wdi;
    end
    exp_addr = a; exp_ir = ir; lat_rd = lr; lat_wr = lw;
    en0 = n_en; we0 = n_we; ir0 = n_ir;
    wait_ready();
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = a;
    bus.cmd_wdata = wd; bus.cmd_mask = m; bus.cmd_int_reg = ir;
    step();
    bus.cmd_valid = 1'b0;
    t = 1;
    while (!bus.rsp_valid && t < 60) begin
      check("cmd_ready_busy", bus.cmd_ready, 1'b0);
      step();
      t++;
    end
    check("latency", t, k);
    check("rsp_err", bus.rsp_err, ee);
    check("rsp_rdata", bus.rsp_rdata, er);
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", bus.rsp_valid, 1'b1);
      check("hold_rdata", bus.rsp_rdata, er);
      check("hold_err", bus.rsp_err, ee);
      check("hold_cmd_ready", bus.cmd_ready, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("rsp_drop", bus.rsp_valid, 1'b0);
    check("ready_back", bus.cmd_ready, 1'b1);
    for (int i = 0; i < 40 && pending; i++) step();
    check("slave_idle", pending, 1'b0);
    check("en_pulses", n_en - en0, ep);
    check("we_pulses", n_we - we0, ew);
    check("ir_pulses", n_ir - ir0, ir ? ep : 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1'b0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
    check({tag, "_rsp_err"}, bus.rsp_err, 2'd0);
    check({tag, "_drpaddr"}, bus.drpaddr, 11'h0);
    check({tag, "_drpdi"}, bus.drpdi, 32'h0);
    check({tag, "_drpen"}, bus.drpen, 1'b0);
    check({tag, "_drpwe"}, bus.drpwe, 1'b0);
    check({tag, "_int_reg"}, bus.int_reg, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [1:0]  op;
    logic [10:0] a;
    int          r, lr, lw;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.cmd_mask = '0; bus.cmd_int_reg = 1'b0; bus.rsp_ready = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();
    check("cmd_ready_after_reset", bus.cmd_ready, 1'b1);

    run_cmd(2'd1, 11'h005, 32'h0000_ABCD, 32'h0, 1'b0, 1, 3, 0);
    run_cmd(2'd1, 11'h203, 32'h1234_5678, 32'h0, 1'b0, 1, 1, 0);
    run_cmd(2'd0, 11'h203, 32'h0, 32'h0, 1'b1, 1, 1, 0);
    run_cmd(2'd1, 11'h010, 32'h1111_2222, 32'h0, 1'b0, 1, 1, 0);
    run_cmd(2'd2, 11'h010, 32'hFFFF_0000, 32'h00FF_0000, 1'b1, 1, 1, 0);
    run_cmd(2'd0, 11'h010, 32'h0, 32'h0, 1'b0, 1, 1, 0);
    run_cmd(2'd0, 11'h020, 32'h0, 32'h0, 1'b0, T + 4, 1, 0);
    run_cmd(2'd0, 11'h005, 32'h0, 32'h0, 1'b0, 2, 1, 0);
    run_cmd(2'd0, 11'h1FF, 32'h0, 32'h0, 1'b0, T, 1, 0);
    run_cmd(2'd0, 11'h1FF, 32'h0, 32'h0, 1'b0, T + 1, 1, 0);
    run_cmd(2'd2, 11'h011, 32'hA5A5_A5A5, 32'hF0F0_F0F0, 1'b0, 0, 1, 0);
    run_cmd(2'd2, 11'h012, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 1'b0, 2, T, 0);
    run_cmd(2'd1, 11'h400, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 1, 0);
    run_cmd(2'd3, 11'h001, 32'hDEAD_BEEF, 32'h0, 1'b0, 1, 1, 0);
    run_cmd(2'd0, 11'h005, 32'h0, 32'h0, 1'b0, 1, 1, 10);

    // Abort during RD_WAIT; the slave still answers later and must be ignored.
    wait_ready();
    exp_addr = 11'h007; lat_rd = 5;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_addr = 11'h007; bus.cmd_int_reg = 1'b0;
    step();
    bus.cmd_valid = 1'b0;
    step();
    chk_on = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    step();
    rst_n = 1'b1;
    step();
    check("cmd_ready_after_abort", bus.cmd_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      check("stray_rdy_valid", bus.rsp_valid, 1'b0);
      check("stray_rdy_drpen", bus.drpen, 1'b0);
    end
    check("abort_slave_idle", pending, 1'b0);
    chk_on = 1'b1;
    run_cmd(2'd0, 11'h005, 32'h0, 32'h0, 1'b0, 1, 1, 0);

    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      if (op == 2'd3 && $urandom_range(0, 1) == 0) op = 2'd0;
      a = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 3) != 0) a[10] = 1'b0;
      if ($urandom_range(0, 1) == 0) a = 11'($urandom_range(0, 7));
      r  = $urandom_range(0, 11);
      lr = (r == 0) ? 0 : (r == 1) ? T + $urandom_range(1, 3) : $urandom_range(1, T);
      r  = $urandom_range(0, 11);
      lw = (r == 0) ? 0 : (r == 1) ? T + $urandom_range(1, 3) : $urandom_range(1, T);
      run_cmd(op, a, $urandom(), $urandom(), 1'($urandom_range(0, 1)), lr, lw,
              $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
